// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for the bit-serial subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done request and result bundle between a controller and the subtractor
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full subtractor built from two half-subtractor stages
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    // First stage x - y, second stage subtracts the incoming borrow from that difference.
    assign w_d1 = x ^ y;
    assign w_b1 = ~x & y;
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;
    assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a - b, LSB first, one bit per clock behind start/done
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_diff;
    logic             r_bflop;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_part_next;

    full_subtractor u_cell (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_bflop),
        .d    (w_d),
        .bout (w_bout)
    );

    // Result bits enter at the MSB so after WIDTH steps bit 0 lands in position 0.
    assign w_part_next = (r_part >> 1) | {w_d, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_part   <= '0;
            r_diff   <= '0;
            r_bflop  <= 1'b0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_part  <= '0;
                        r_bflop <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_part  <= w_part_next;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_bflop <= w_bout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_diff   <= w_part_next;
                        r_borrow <= w_bout;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic and an unsigned compare.
    function automatic logic [8:0] ref_sub(input int w, input int unsigned a, input int unsigned b);
        int unsigned mask;
        mask = (32'd1 << w) - 32'd1;
        return {(a < b), 8'((a - b) & mask)};
    endfunction

    // Issues one request and waits for done; lat counts edges with the accepting edge as edge 1.
    task automatic op(input bit w4, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] d, output logic bo, output int lat, output int bcyc,
                      output logic busy_at_done);
        logic bsy, dn;
        bit   got;
        got = 0; d = '0; bo = 1'b0; bcyc = 0; busy_at_done = 1'b0;
        @(negedge clk);
        if (w4) begin bus4.start = 1'b1; bus4.a = a[3:0]; bus4.b = b[3:0]; end
        else    begin bus8.start = 1'b1; bus8.a = a;      bus8.b = b;      end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus4.start = 1'b0;
        bus8.start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            bsy = w4 ? bus4.busy : bus8.busy;
            dn  = w4 ? bus4.done : bus8.done;
            if (dn) begin
                d            = w4 ? {4'h0, bus4.diff} : bus8.diff;
                bo           = w4 ? bus4.borrow : bus8.borrow;
                busy_at_done = bsy;
                got          = 1;
                break;
            end
            if (bsy) bcyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!got) check("op_timeout", 32'd0, 32'd1);
    endtask

    vec_t       vecs[10];
    logic [7:0] d;
    logic       bo;
    logic       bad;
    int         lat, bcyc, ndone;
    logic [8:0] exp;
    int         done_at[$];
    bit         prev_done;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[6] = '{8'h09, 8'h04, 8'h05, 1'b0};
        vecs[7] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[8] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[9] = '{8'h20, 8'h10, 8'h10, 1'b0};

        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        #12;
        check("reset_busy",   {31'd0, bus8.busy},   32'd0);
        check("reset_done",   {31'd0, bus8.done},   32'd0);
        check("reset_diff",   {24'd0, bus8.diff},   32'd0);
        check("reset_borrow", {31'd0, bus8.borrow}, 32'd0);
        check("reset_diff4",  {28'd0, bus4.diff},   32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            op(1'b0, vecs[i].a, vecs[i].b, d, bo, lat, bcyc, bad);
            check($sformatf("tbl%0d_diff", i),   {24'd0, d},  {24'd0, vecs[i].diff});
            check($sformatf("tbl%0d_borrow", i), {31'd0, bo}, {31'd0, vecs[i].borrow});
            check($sformatf("tbl%0d_latency", i), lat, 32'd9);
            check($sformatf("tbl%0d_busy_cycles", i), bcyc, 32'd8);
            check($sformatf("tbl%0d_busy_with_done", i), {31'd0, bad}, 32'd0);
            @(negedge clk);
            check($sformatf("tbl%0d_done_one_cycle", i), {31'd0, bus8.done}, 32'd0);
        end

        // start during SHIFT must be ignored
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h00;
        @(negedge clk);
        bus8.start = 1'b0;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus8.done) begin ndone++; d = bus8.diff; bo = bus8.borrow; end
            @(negedge clk);
        end
        check("ignore_done_count", ndone, 32'd1);
        check("ignore_diff",   {24'd0, d},  32'h0F);
        check("ignore_borrow", {31'd0, bo}, 32'd0);

        // back-to-back with start held high
        bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h7F;
        prev_done = 0;
        for (int n = 0; n < 60 && done_at.size() < 3; n++) begin
            if (prev_done) check("b2b_busy_after_done", {31'd0, bus8.busy}, 32'd1);
            prev_done = bus8.done;
            if (bus8.done) begin
                done_at.push_back(n);
                check("b2b_diff",   {24'd0, bus8.diff},   32'h01);
                check("b2b_borrow", {31'd0, bus8.borrow}, 32'd0);
            end
            @(negedge clk);
        end
        check("b2b_busy_after_done", {31'd0, bus8.busy}, 32'd1);
        bus8.start = 1'b0;
        check("b2b_done_count", done_at.size(), 32'd3);
        if (done_at.size() == 3) begin
            check("b2b_period1", done_at[1] - done_at[0], 32'd9);
            check("b2b_period2", done_at[2] - done_at[1], 32'd9);
        end
        for (int n = 0; n < 20 && !bus8.done; n++) @(negedge clk);
        check("b2b_drain_done", {31'd0, bus8.done}, 32'd1);
        @(negedge clk);

        // asynchronous reset in the middle of an operation
        bus8.start = 1'b1; bus8.a = 8'h20; bus8.b = 8'h10;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, bus8.busy},   32'd0);
        check("arst_done",   {31'd0, bus8.done},   32'd0);
        check("arst_diff",   {24'd0, bus8.diff},   32'd0);
        check("arst_borrow", {31'd0, bus8.borrow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            if (bus8.done || bus8.busy) ndone++;
            @(negedge clk);
        end
        check("arst_no_activity", ndone, 32'd0);
        op(1'b0, 8'h09, 8'h04, d, bo, lat, bcyc, bad);
        check("arst_after_diff",   {24'd0, d},  32'h05);
        check("arst_after_borrow", {31'd0, bo}, 32'd0);

        // random sweeps against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op(1'b0, ra, rb, d, bo, lat, bcyc, bad);
            exp = ref_sub(8, ra, rb);
            check("rnd8", {23'd0, bo, d}, {23'd0, exp});
        end
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            op(1'b1, ra, rb, d, bo, lat, bcyc, bad);
            exp = ref_sub(4, ra, rb);
            check("rnd4", {23'd0, bo, d}, {23'd0, exp});
            if (i == 0) check("rnd4_latency", lat, 32'd5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes diff = a - b and borrow-out for two WIDTH-bit operands.
- Processes one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow.
- It is the inverse-operation counterpart of the team's half-adder datapath cell.
- Sits behind a simple start/done handshake so a controller or bench can issue one subtraction at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising clk edge; accepted only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle pulse; high while in DONE.
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
- borrow  output  1  registered borrow-out; 1 iff a < b (unsigned).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0. Internal bit counter, operand shift registers, borrow flop and partial-result register are all 0.
- States:
  - IDLE: waiting for a request.
  - SHIFT: WIDTH bit-steps.
  - DONE: one cycle, then IDLE.
- Accepting edge (start=1 in IDLE or DONE):
  - Load a and b into their shift registers.
  - Clear the borrow flop and counter.
  - Go to SHIFT.
- Each SHIFT edge:
  - Bit cell inputs: x = a_sr[0], y = b_sr[0], bin = borrow flop.
  - Bit cell outputs: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
  - Shift d into the MSB of the partial result (right shift).
  - Shift both operand registers right by 1.
  - Borrow flop <= bout.
  - Counter increments.
- Completion: on the SHIFT edge where counter == WIDTH-1:
  - Load diff <= completed partial result and borrow <= bout for that bit.
  - Go to DONE.
- Latency: done is high during the cycle that starts WIDTH+1 edges after the accepting edge. Throughput is one operation per WIDTH+1 cycles.
- diff and borrow hold their values from completion until the next completion or reset. They do not change during SHIFT.
- start while in SHIFT is ignored; a, b and the in-flight result are unaffected.
- start during DONE is accepted: done still pulses for exactly one cycle, then busy=1 on the next cycle with no IDLE gap.
- start held high continuously gives back-to-back operations, each re-sampling a and b at its accepting edge.
- rst asserted mid-operation aborts immediately (asynchronously) to reset values. No done pulse is produced for the aborted operation.
- busy and done are never high together.
- Arithmetic: unsigned, modulo 2^WIDTH; no signed interpretation.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, and the default WIDTH.
- Counter width: $clog2(WIDTH), computed locally.
- Sub-module full_subtractor: purely combinational 1-bit cell with inputs x, y, bin and outputs d, bout, built from two half-subtractor stages. It is instantiated once in the datapath.
- The FSM, shift registers and output registers stay in serial_subtractor.

Test Plan:
- After reset, a=8'h05, b=8'h03, start pulse for 1 cycle -> busy=1 for 8 cycles; done=1 exactly 9 edges after the accepting edge; diff=8'h02, borrow=0.
- a=8'h03, b=8'h05 -> diff=8'hFE, borrow=1. Then a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1. Then a=8'hFF, b=8'hFF -> diff=8'h00, borrow=0.
- Start 8'h10-8'h01; at the 3rd SHIFT cycle drive start=1 with a=8'hAA, b=8'h00 -> ignored; result diff=8'h0F, borrow=0; exactly one done pulse.
- Hold start=1 continuously with a=8'h80, b=8'h7F -> done pulses every 9 cycles, each with diff=8'h01, borrow=0; busy rises on the cycle after each done with no IDLE cycle.
- Assert rst asynchronously mid-SHIFT of 8'h20-8'h10 -> busy, done, diff and borrow go to 0 immediately. No done pulse after rst is released until a new start; a new 8'h09-8'h04 then gives diff=8'h05.
- Random sweep of 1000 a,b pairs at WIDTH=8 and WIDTH=4 -> diff == (a-b) mod 2^WIDTH and borrow == (a<b) at every done.
